// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly in front of the decoder/controller.
// Owns the program counter and issues one outstanding word read at a time to
// instruction memory. The returned word is captured in an instruction register
// and offered downstream with a valid/ready handshake. Jump redirect and halt
// are decided by the downstream stage and take effect only at the moment it
// consumes the instruction.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   imem_req       read request, high for the whole REQ state
//   imem_addr      word address of the read (always equal to pc)
//   imem_ack       read data valid on imem_rdata this cycle
//   imem_rdata     instruction word from memory
//   inst           instruction register towards the decoder
//   inst_valid     inst holds a fetched, not yet consumed instruction
//   inst_ready     downstream consumes inst this cycle
//   jump           redirect request, used only on consume
//   jump_target    redirect address, used only on consume
//   is_halt        halt request, used only on consume (wins over jump)
//   pc             address of the instruction in inst, or being fetched
//   pc_plus1       pc + 1 modulo 2^ADDR_W, base for relative branches
//   halted         fetch permanently stopped until reset
//   retired        number of consumed instructions (wraps)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              is_halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              halted,
  output logic [15:0]       retired
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // one quiet cycle after reset; stale acks land here
    REQ    = 2'd1,  // read outstanding at pc
    HOLD   = 2'd2,  // inst valid, waiting for the consumer
    HALTED = 2'd3   // terminal until reset
  } state_t;

  state_t state;
  state_t next_state;
  logic   consume;
  logic   fill;

  // A consume can only happen while an instruction is being offered.
  assign consume = (state == HOLD) && inst_valid && inst_ready;

  // Memory data is only accepted while our own request is outstanding, so an
  // ack belonging to a request abandoned by reset is dropped in IDLE.
  assign fill = (state == REQ) && imem_ack;

  // Outputs are pure decodes of the registered state (no path from imem_ack
  // to imem_req), which keeps the memory interface free of combinational loops.
  assign imem_req  = (state == REQ);
  assign halted    = (state == HALTED);
  assign imem_addr = pc;
  assign pc_plus1  = pc + ADDR_W'(1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values of its neighbours; = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so that every path assigns
  // it; a missing branch would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        next_state = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (consume) begin
          next_state = is_halt ? HALTED : REQ;
        end
      end
      HALTED: begin
        next_state = HALTED;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: pc, instruction register, valid flag, retire counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
      retired    <= '0;
    end else begin
      if (fill) begin
        inst       <= imem_rdata;
        inst_valid <= 1'b1;
      end

      if (consume) begin
        retired    <= retired + 16'd1;
        inst_valid <= 1'b0;
        // On halt pc keeps pointing at the halting instruction.
        if (!is_halt) begin
          pc <= jump ? jump_target : pc_plus1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural memory answers requests
// after a programmable number of cycles with 0x8000+addr (or a fixed word).
// A small reference model of pc/retired/halted pushes the expected fetch
// address into a queue whenever it sees a consume; the memory pushes the word
// it returns into a second queue. Both queues are popped and compared when the
// DUT starts a request or raises inst_valid.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack    = 1'b0;
  logic [15:0] imem_rdata  = 16'h0000;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready  = 1'b0;
  logic        jump        = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic        is_halt     = 1'b0;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        halted;
  logic [15:0] retired;

  fetch_unit #(
    .ADDR_W   (16),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .jump        (jump),
    .jump_target (jump_target),
    .is_halt     (is_halt),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  // Bookkeeping
  int n_checks = 0;
  int n_errors = 0;

  // Reference model and scoreboard
  logic [15:0] pc_m;
  logic [15:0] ret_m;
  logic        halted_m;
  logic [15:0] addr_q[$];
  logic [15:0] inst_q[$];

  // Memory model knobs
  int          mem_delay   = 0;
  logic        data_ovr_en = 1'b0;
  logic [15:0] data_ovr    = 16'h0000;
  logic        stray_ack   = 1'b0;
  logic        auto_ready  = 1'b0;

  // Monitor history
  logic        prev_req   = 1'b0;
  logic        prev_valid = 1'b0;
  logic [15:0] held_addr;
  logic [15:0] held_inst;
  int          req_age     = 0;
  int          last_req_len = 0;
  int          valid_rises = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: update the model from the pre-edge handshake, compare
  // after the edge, then drive memory/ready for the next edge.
  task automatic tick();
    logic        cons;
    logic [15:0] e;
    logic [15:0] p1;
    cons = rst_n && inst_valid && inst_ready && !halted_m;
    @(posedge clk);
    if (cons) begin
      ret_m = ret_m + 16'd1;
      if (is_halt) begin
        halted_m = 1'b1;
      end else begin
        pc_m = jump ? jump_target : pc_m + 16'd1;
        addr_q.push_back(pc_m);
      end
    end
    #1;
    p1 = pc_m + 16'd1;
    check("pc", 32'(pc), 32'(pc_m));
    check("pc_plus1", 32'(pc_plus1), 32'(p1));
    check("retired", 32'(retired), 32'(ret_m));
    check("halted", 32'(halted), 32'(halted_m));
    if (halted_m) begin
      check("halted_req", 32'(imem_req), 32'd0);
      check("halted_valid", 32'(inst_valid), 32'd0);
    end
    if (imem_req && !prev_req) begin
      if (addr_q.size() == 0) begin
        check("req_unexpected", 32'd1, 32'd0);
      end else begin
        e = addr_q.pop_front();
        check("fetch_addr", 32'(imem_addr), 32'(e));
      end
      held_addr = imem_addr;
      req_age   = 0;
    end else if (imem_req) begin
      check("addr_stable", 32'(imem_addr), 32'(held_addr));
      req_age++;
    end
    if (inst_valid && !prev_valid) begin
      valid_rises++;
      if (inst_q.size() == 0) begin
        check("valid_unexpected", 32'd1, 32'd0);
      end else begin
        e = inst_q.pop_front();
        check("inst", 32'(inst), 32'(e));
      end
      held_inst = inst;
    end else if (inst_valid) begin
      check("inst_stable", 32'(inst), 32'(held_inst));
    end
    prev_req   = imem_req;
    prev_valid = inst_valid;

    // Memory response for the coming edge
    if (imem_req && req_age >= mem_delay) begin
      imem_ack     = 1'b1;
      imem_rdata   = data_ovr_en ? data_ovr : 16'h8000 + imem_addr;
      inst_q.push_back(imem_rdata);
      last_req_len = req_age + 1;
    end else begin
      imem_ack   = stray_ack;
      imem_rdata = 16'hDEAD;
    end
    if (auto_ready) inst_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    inst_ready = 1'b0;
    jump       = 1'b0;
    is_halt    = 1'b0;
    imem_ack   = stray_ack;
    pc_m       = RESET_PC;
    ret_m      = 16'd0;
    halted_m   = 1'b0;
    addr_q.delete();
    inst_q.delete();
    addr_q.push_back(RESET_PC);
    prev_req   = 1'b0;
    prev_valid = 1'b0;
    #1;
    check("rst_pc", 32'(pc), 32'(RESET_PC));
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50; i++) begin
      if (inst_valid) return;
      tick();
    end
    check("timeout_valid", 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      if (imem_req) return;
      tick();
    end
    check("timeout_req", 32'(imem_req), 32'd1);
  endtask

  // Wait for an offered instruction and consume it with the given controls.
  task automatic consume(input logic j, input logic [15:0] tgt, input logic h);
    wait_valid();
    inst_ready  = 1'b1;
    jump        = j;
    jump_target = tgt;
    is_halt     = h;
    tick();
    inst_ready  = 1'b0;
    jump        = 1'b0;
    is_halt     = 1'b0;
  endtask

  initial begin
    #2;
    // ---- Zero-wait memory, always ready: 2 cycles per instruction ----------
    do_reset();
    auto_ready  = 1'b1;
    valid_rises = 0;
    for (int i = 0; i < 9; i++) tick();
    check("retired_after_4", 32'(retired), 32'd4);
    check("valid_pulses", 32'(valid_rises), 32'd4);
    auto_ready = 1'b0;
    inst_ready = 1'b0;

    // ---- 3-cycle memory latency, then stall in HOLD for 5 cycles ------------
    mem_delay   = 3;
    data_ovr_en = 1'b1;
    data_ovr    = 16'h1234;
    consume(1'b0, 16'h0000, 1'b0);
    wait_req();
    // jump/halt without a consume must be ignored
    jump        = 1'b1;
    jump_target = 16'h0F0F;
    is_halt     = 1'b1;
    wait_valid();
    check("slow_req_len", 32'(last_req_len), 32'd4);
    check("slow_inst", 32'(inst), 32'h1234);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_no_req", 32'(imem_req), 32'd0);
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_inst", 32'(inst), 32'h1234);
    end
    jump        = 1'b0;
    is_halt     = 1'b0;
    mem_delay   = 0;
    data_ovr_en = 1'b0;
    consume(1'b0, 16'h0000, 1'b0);
    wait_req();
    check("after_hold_addr", 32'(imem_addr), 32'h0006);

    // ---- Jumps, wrap-around and halt-over-jump priority ---------------------
    consume(1'b1, 16'h0010, 1'b0);
    wait_valid();
    check("pc_at_jump", 32'(pc), 32'h0010);
    consume(1'b1, 16'h0040, 1'b0);
    wait_req();
    check("jump_addr", 32'(imem_addr), 32'h0040);
    check("jump_pc_plus1", 32'(pc_plus1), 32'h0041);
    consume(1'b1, 16'hFFFF, 1'b0);
    wait_valid();
    check("pc_plus1_wrap", 32'(pc_plus1), 32'h0000);
    consume(1'b0, 16'h0000, 1'b0);
    wait_req();
    check("wrap_addr", 32'(imem_addr), 32'h0000);
    consume(1'b1, 16'h0020, 1'b1);
    tick();
    check("jh_halted", 32'(halted), 32'd1);
    check("jh_pc", 32'(pc), 32'h0000);
    do_reset();

    // ---- Halt, then noise on every input for 20 cycles ----------------------
    consume(1'b0, 16'h0000, 1'b1);
    check("halt_flag", 32'(halted), 32'd1);
    auto_ready = 1'b1;
    stray_ack  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      jump        = i[0];
      is_halt     = i[1];
      jump_target = 16'(i * 7);
      tick();
      check("halted_quiet", 32'(imem_req), 32'd0);
    end
    auto_ready = 1'b0;
    stray_ack  = 1'b0;
    do_reset();
    wait_valid();
    check("restart_inst", 32'(inst), 32'h8000);
    check("restart_retired", 32'(retired), 32'd0);

    // ---- Reset during an outstanding request, late ack in IDLE --------------
    consume(1'b0, 16'h0000, 1'b0);
    mem_delay = 10;
    wait_req();
    check("pending_addr", 32'(imem_addr), 32'h0001);
    tick();
    tick();
    stray_ack = 1'b1;
    mem_delay = 0;
    do_reset();
    tick();
    check("late_ack_valid", 32'(inst_valid), 32'd0);
    check("late_ack_req", 32'(imem_req), 32'd1);
    check("late_ack_addr", 32'(imem_addr), 32'(RESET_PC));
    stray_ack = 1'b0;
    wait_valid();
    check("late_ack_inst", 32'(inst), 32'h8000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
